// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 multi-port register bank.
// Holds the default geometry and the dump FSM state type.
package mips32_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } dump_state_t;

endpackage

// File: rtl/mips32_regfile_dump_fsm.sv
// Register-dump stream controller for mips32_regfile_mp.
// Walks idx from 0 to NUM_REGS-1, presenting one register per beat on a
// valid/ready handshake, then emits a one-cycle done pulse.
// Ports:
//   clk1, rst_n          clock, async active-low reset
//   dump_start           start request, only honoured in IDLE
//   dump_ready           sink ready
//   rd_idx / rd_data     index sent to the parent, stored value returned
//   dump_valid/addr/data beat outputs (zero outside STREAM)
//   dump_done            one-cycle pulse after the last accepted beat
//   dump_busy            FSM not in IDLE
//
// state  | meaning
// IDLE   | waiting for dump_start
// STREAM | presenting reg[idx], advancing on each accepted beat
// DONE   | single-cycle completion pulse
module mips32_regfile_dump_fsm
  import mips32_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS_DEF)
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done,
  output logic              dump_busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dump_valid = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    dump_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        dump_valid = 1'b1;
        dump_addr  = idx_q;
        dump_data  = rd_data;
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        dump_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_idx    = idx_q;
  assign dump_busy = (state_q != IDLE);

endmodule

// File: rtl/mips32_regfile_mp.sv
// Multi-read-port register bank for the pipelined MIPS32 core.
// R0 is hard zero. Pipeline writes are bypassed to the read ports in the
// same cycle; debug-port writes are not and show up one cycle later.
// Ports:
//   clk1, rst_n                 clock, async active-low reset
//   we / waddr / wdata          pipeline (WB) write port
//   raddr / rdata               packed read ports, port i at slice i
//   dbg_we/dbg_addr/dbg_wdata   debug load port (loses to pipeline on clash)
//   dump_*                      register-dump stream, see dump FSM
module mips32_regfile_mp
  import mips32_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int NUM_RD   = 2,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     dbg_we,
  input  logic [ADDR_W-1:0]        dbg_addr,
  input  logic [DATA_W-1:0]        dbg_wdata,
  input  logic                     dump_start,
  input  logic                     dump_ready,
  output logic                     dump_valid,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done,
  output logic                     dump_busy
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_rd_data;

  // Loop starts at 1 so R0 is never written and keeps its reset value of 0.
  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (we && waddr == ADDR_W'(r)) begin
        regs_d[r] = wdata;
      end else if (dbg_we && dbg_addr == ADDR_W'(r)) begin
        regs_d[r] = dbg_wdata;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[p*ADDR_W +: ADDR_W];
    assign rdata[p*DATA_W +: DATA_W] =
      (ra == '0)              ? {DATA_W{1'b0}} :
      (we && (waddr == ra))   ? wdata :
                                regs_q[ra];
  end

  // Dump reads the stored array directly, never the bypass path.
  assign dump_rd_data = regs_q[dump_idx];

  mips32_regfile_dump_fsm #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_dump_fsm (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .rd_idx     (dump_idx),
    .rd_data    (dump_rd_data),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done),
    .dump_busy  (dump_busy)
  );

endmodule

// File: tb/tb_mips32_regfile_mp.sv
module tb_mips32_regfile_mp;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic rst_n;

  // default build: 32 regs, 2 read ports
  logic        we, dbg_we, dump_start, dump_ready;
  logic [4:0]  waddr, dbg_addr;
  logic [31:0] wdata, dbg_wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        dump_valid, dump_done, dump_busy;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;

  // small build: 16 regs, 3 read ports
  logic        we2, dbg_we2, dump_start2, dump_ready2;
  logic [3:0]  waddr2, dbg_addr2;
  logic [31:0] wdata2, dbg_wdata2;
  logic [11:0] raddr2;
  logic [95:0] rdata2;
  logic        dump_valid2, dump_done2, dump_busy2;
  logic [3:0]  dump_addr2;
  logic [31:0] dump_data2;

  mips32_regfile_mp dut (
    .clk1(clk1), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dump_start(dump_start), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done), .dump_busy(dump_busy)
  );

  mips32_regfile_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) dut2 (
    .clk1(clk1), .rst_n(rst_n), .we(we2), .waddr(waddr2), .wdata(wdata2),
    .raddr(raddr2), .rdata(rdata2), .dbg_we(dbg_we2), .dbg_addr(dbg_addr2),
    .dbg_wdata(dbg_wdata2), .dump_start(dump_start2), .dump_ready(dump_ready2),
    .dump_valid(dump_valid2), .dump_addr(dump_addr2), .dump_data(dump_data2),
    .dump_done(dump_done2), .dump_busy(dump_busy2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mdl  [32];
  logic [31:0] mdl2 [16];

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // expected read of the default build: zero for R0, bypass of a pending
  // pipeline write, otherwise the stored value
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we && waddr == a) return wdata;
    return mdl[a];
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int i = 0; i < 16; i++) mdl2[i] = '0;
  endtask

  // advance one clock; update the models with what was committed
  task automatic tick();
    @(posedge clk1);
    if (rst_n) begin
      if (dbg_we && dbg_addr != 0) mdl[dbg_addr] = dbg_wdata;
      if (we && waddr != 0) mdl[waddr] = wdata;
      if (dbg_we2 && dbg_addr2 != 0) mdl2[dbg_addr2] = dbg_wdata2;
      if (we2 && waddr2 != 0) mdl2[waddr2] = wdata2;
    end
    @(negedge clk1);
  endtask

  task automatic idle_inputs();
    we = 0; waddr = 0; wdata = 0; raddr = 0;
    dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    dump_start = 0; dump_ready = 0;
    we2 = 0; waddr2 = 0; wdata2 = 0; raddr2 = 0;
    dbg_we2 = 0; dbg_addr2 = 0; dbg_wdata2 = 0;
    dump_start2 = 0; dump_ready2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    clear_models();
    tick();
    tick();
    rst_n = 1;
  endtask

  // Runs a dump of the default build that is already in STREAM.
  // mode 0: ready alternates 1,0,1..; mode 1: random ready plus random writes.
  task automatic run_dump1(input int mode);
    int  beat;
    bit  fin;
    bit  acc;
    beat = 0;
    fin  = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      acc        = 0;
      dump_start = (c == 7);
      dump_ready = (mode == 0) ? (c % 2 == 0) : 1'($urandom % 2);
      if (mode == 1) begin
        we        = 1'($urandom % 2);
        waddr     = 5'($urandom_range(0, 31));
        wdata     = $urandom;
        dbg_we    = 1'($urandom % 2);
        dbg_addr  = 5'($urandom_range(0, 31));
        dbg_wdata = $urandom;
      end
      #2;
      if (beat < 32) begin
        chk("dump_valid", dump_valid, 1);
        chk("dump_addr", dump_addr, beat);
        chk("dump_data", dump_data, mdl[beat]);
        chk("dump_done_early", dump_done, 0);
        chk("dump_busy", dump_busy, 1);
        acc = dump_ready;
      end else begin
        chk("dump_done_pulse", dump_done, 1);
        chk("dump_valid_in_done", dump_valid, 0);
        fin = 1;
      end
      tick();
      if (acc) beat++;
    end
    if (!fin) chk("dump_timeout", 0, 1);
    idle_inputs();
    #2;
    chk("dump_done_once", dump_done, 0);
    chk("dump_busy_after", dump_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int beats2;
    bit fin2;
    idle_inputs();
    rst_n = 0;
    clear_models();
    tick();
    #2;
    raddr = {5'd3, 5'd1};
    #1;
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_busy", dump_busy, 0);
    chk("rst_done", dump_done, 0);
    chk("rst_daddr", dump_addr, 0);
    chk("rst_ddata", dump_data, 0);
    chk("rst_rdata2", rdata2, 96'd0);
    tick();
    rst_n = 1;

    // registers written then cleared by async reset
    dbg_we = 1; dbg_addr = 1; dbg_wdata = 32'hAA;
    we = 1; waddr = 2; wdata = 32'hBB;
    tick();
    idle_inputs();
    raddr = {5'd2, 5'd1};
    #2;
    chk("pre_rst_r1", rdata[31:0], 32'hAA);
    chk("pre_rst_r2", rdata[63:32], 32'hBB);
    rst_n = 0;
    clear_models();
    #2;
    chk("async_rst_clear", rdata, 64'd0);
    tick();
    rst_n = 1;

    // bypass
    we = 1; waddr = 1; wdata = 10; raddr = {5'd0, 5'd1};
    #2;
    chk("byp_same_cycle", rdata[31:0], 32'd10);
    chk("byp_r0_port1", rdata[63:32], 32'd0);
    tick();
    we = 0;
    #2;
    chk("byp_next_cycle", rdata[31:0], 32'd10);
    dbg_we = 1; dbg_addr = 2; dbg_wdata = 55; raddr = {5'd2, 5'd1};
    #2;
    chk("dbg_no_bypass", rdata[63:32], 32'd0);
    tick();
    dbg_we = 0;
    #2;
    chk("dbg_visible_next", rdata[63:32], 32'd55);

    // R0 and arbitration
    we = 1; waddr = 0; wdata = 5; raddr = {5'd0, 5'd0};
    #2;
    chk("r0_write_same", rdata[31:0], 32'd0);
    tick();
    we = 0;
    #2;
    chk("r0_write_after", rdata[31:0], 32'd0);
    we = 1; waddr = 4; wdata = 30;
    dbg_we = 1; dbg_addr = 4; dbg_wdata = 99;
    tick();
    idle_inputs();
    raddr = {5'd0, 5'd4};
    #2;
    chk("arb_pipe_wins", rdata[31:0], 32'd30);
    dbg_we = 1; dbg_addr = 0; dbg_wdata = 123;
    tick();
    dbg_we = 0;
    raddr = 0;
    #2;
    chk("r0_dbg_write", rdata[31:0], 32'd0);

    // randomized read/write traffic
    for (int c = 0; c < 400; c++) begin
      we        = 1'($urandom % 2);
      waddr     = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wdata     = $urandom;
      dbg_we    = 1'($urandom % 2);
      dbg_addr  = ($urandom % 2) ? waddr : 5'($urandom_range(0, 7));
      dbg_wdata = $urandom;
      raddr[4:0] = ($urandom % 3 == 0) ? waddr : 5'($urandom_range(0, 7));
      raddr[9:5] = ($urandom % 3 == 0) ? dbg_addr : 5'($urandom_range(0, 31));
      #2;
      chk("rnd_rd0", rdata[31:0], exp_rd(raddr[4:0]));
      chk("rnd_rd1", rdata[63:32], exp_rd(raddr[9:5]));
      tick();
    end
    idle_inputs();

    // dump with backpressure
    do_reset();
    dbg_we = 1; dbg_addr = 1; dbg_wdata = 10; tick();
    dbg_addr = 2; dbg_wdata = 20; tick();
    dbg_addr = 3; dbg_wdata = 25; tick();
    idle_inputs();
    dump_start = 1;
    #2;
    chk("busy_before_start", dump_busy, 0);
    tick();
    dump_start = 0;
    #2;
    chk("beat0_data", dump_data, 32'd0);
    chk("beat0_valid", dump_valid, 1);
    run_dump1(0);

    // reset mid-dump
    dump_start = 1; tick(); dump_start = 0;
    dump_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("abort_beat_addr", dump_addr, i);
      tick();
    end
    rst_n = 0;
    clear_models();
    #2;
    chk("abort_valid", dump_valid, 0);
    chk("abort_busy", dump_busy, 0);
    chk("abort_done", dump_done, 0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("abort_no_done", dump_done, 0);
      chk("abort_idle", dump_busy, 0);
      tick();
    end
    dump_ready = 0;
    dump_start = 1; tick(); dump_start = 0;
    #2;
    chk("restart_addr0", dump_addr, 0);
    run_dump1(1);

    // 16-register, 3-port build
    do_reset();
    dbg_we2 = 1; dbg_addr2 = 1; dbg_wdata2 = 32'h1234; tick();
    dbg_we2 = 0;
    raddr2 = {4'd0, 4'd15, 4'd1};
    we2 = 1; waddr2 = 15; wdata2 = 77;
    #2;
    chk("p3_bypass", rdata2, {32'd0, 32'd77, 32'h1234});
    tick();
    we2 = 0;
    #2;
    chk("p3_stored", rdata2[63:32], 32'd77);
    dump_start2 = 1; tick(); dump_start2 = 0;
    dump_ready2 = 1;
    beats2 = 0;
    fin2   = 0;
    for (int c = 0; c < 60 && !fin2; c++) begin
      #2;
      if (dump_done2) fin2 = 1;
      else if (dump_valid2) begin
        chk("d2_addr", dump_addr2, beats2[3:0]);
        chk("d2_data", dump_data2, mdl2[beats2[3:0]]);
        beats2++;
      end
      tick();
    end
    chk("d2_finished", fin2, 1);
    chk("d2_beats", beats2, 16);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
